// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded MIPS register file.
// Default sizes, architectural register indices and the pending-count type.
package regfile_sb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_PEND_W   = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_sb_ctr.sv
// Saturating up/down counter tracking in-flight writes to one register.
// inc and dec together leave the count unchanged; dec at zero holds zero.
module regfile_sb_ctr
  import regfile_sb_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              full
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/regfile_sb.sv
// Parametrised MIPS register file with a per-register outstanding-write scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward writeback data/pending state to reads in the same cycle.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int PEND_W   = DEF_PEND_W,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready
);

  // Address space is padded to a power of two; slots for r0 and r>=NUM_REGS
  // are constant zero so reads need no separate range check.
  localparam int SLOTS = 1 << ADDR_W;

  logic [DATA_W-1:0] reg_view [SLOTS];
  logic [PEND_W-1:0] cnt_view [SLOTS];
  logic [SLOTS-1:0]  full_view;
  logic [SLOTS-1:0]  reg_exists;
  logic              wb_live;
  logic              iss_fire;

  assign wb_live = wb_en && reg_exists[wb_addr];

  // Issue handshake: an issue is taken on a rising edge where iss_valid and
  // iss_ready are both high; iss_ready never depends on iss_valid.
  assign iss_ready = !rst && !(full_view[iss_addr] && !(wb_live && (wb_addr == iss_addr)));
  assign iss_fire  = iss_valid && iss_ready;

  for (genvar r = 0; r < SLOTS; r++) begin : g_slot
    if ((r == REG_ZERO) || (r >= NUM_REGS)) begin : g_const
      assign reg_view[r]   = '0;
      assign cnt_view[r]   = '0;
      assign full_view[r]  = 1'b0;
      assign reg_exists[r] = 1'b0;
    end else begin : g_reg
      logic [DATA_W-1:0] reg_q, reg_d;
      logic              wr_hit;
      logic              iss_hit;

      assign wr_hit  = wb_en && (wb_addr == ADDR_W'(r));
      assign iss_hit = iss_fire && (iss_addr == ADDR_W'(r));

      always_comb begin
        reg_d = reg_q;
        if (wr_hit) reg_d = wb_data;
      end

      always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
      end

      regfile_sb_ctr #(.PEND_W(PEND_W)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (iss_hit),
        .dec  (wr_hit),
        .cnt  (cnt_view[r]),
        .full (full_view[r])
      );

      assign reg_view[r]   = reg_q;
      assign reg_exists[r] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
    logic fwd;
    assign fwd = wb_live && (wb_addr == addr);
    assign rd_data[k*DATA_W +: DATA_W] = fwd ? wb_data : reg_view[addr];
    // Pending as if the forwarded write had already retired (saturating at 0).
    assign rd_pending[k] = fwd ? (cnt_view[addr] > PEND_W'(1)) : (cnt_view[addr] != '0);
`else
    assign rd_data[k*DATA_W +: DATA_W] = reg_view[addr];
    assign rd_pending[k] = (cnt_view[addr] != '0);
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with an expected-value queue.
// Honours REGFILE_SB_BYPASS_EN when choosing same-cycle read expectations.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;

  logic [DATA_W-1:0] exp_q [$];
  int n_assert;
  int n_fail;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_ready  (iss_ready)
  );

  // clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic set_rd(input int a0, input int a1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic drive_wb(input bit en, input int addr, input logic [DATA_W-1:0] data);
    wb_en   = en;
    wb_addr = ADDR_W'(addr);
    wb_data = data;
  endtask

  task automatic drive_iss(input bit valid, input int addr);
    iss_valid = valid;
    iss_addr  = ADDR_W'(addr);
  endtask

  // scoreboard
  task automatic ex(input logic [DATA_W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_rd(0, 0);
    drive_wb(1'b0, 0, '0);
    drive_iss(1'b0, 0);

    // reset state
    @(negedge clk); #1;
    ex(0); chk("iss_ready_in_rst", DATA_W'(iss_ready));
    @(negedge clk); rst = 1'b0; #1;
    ex(1); chk("iss_ready_after_rst", DATA_W'(iss_ready));
    for (int a = 0; a < 32; a++) begin
      @(negedge clk); set_rd(a, 31 - a); #1;
      ex(0); chk($sformatf("rst_data_p0_r%0d", a), rd_data[31:0]);
      ex(0); chk($sformatf("rst_data_p1_r%0d", 31 - a), rd_data[63:32]);
      ex(0); chk($sformatf("rst_pend_r%0d", a), DATA_W'(rd_pending));
    end

    // basic write / r0 hardwired
    @(negedge clk); drive_wb(1'b1, 5, 32'hDEADBEEF); set_rd(5, 0);
    @(negedge clk); drive_wb(1'b1, 0, 32'h12345678); #1;
    ex(32'hDEADBEEF); chk("wr_r5", rd_data[31:0]);
    @(negedge clk); drive_wb(1'b0, 0, '0); #1;
    ex(0); chk("wr_r0_p1", rd_data[63:32]);

    // fill r7 to saturation
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_iss(1'b1, 7); set_rd(7, 7); #1;
      ex(1); chk($sformatf("iss_r7_ready_%0d", i), DATA_W'(iss_ready));
    end
    @(negedge clk); #1;
    ex(0);     chk("iss_r7_full", DATA_W'(iss_ready));
    ex(2'b11); chk("pend_r7_full", DATA_W'(rd_pending));
    drive_wb(1'b1, 7, 32'h70); #1;
    ex(1); chk("iss_r7_full_with_wb", DATA_W'(iss_ready));
    @(negedge clk); drive_iss(1'b0, 7); drive_wb(1'b0, 0, '0); #1;
    ex(0);     chk("iss_r7_still_full", DATA_W'(iss_ready));
    ex(32'h70); chk("data_r7_70", rd_data[31:0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_wb(1'b1, 7, 32'h71 + i);
    end
    @(negedge clk); drive_wb(1'b0, 0, '0); #1;
    ex(0);      chk("pend_r7_drained", DATA_W'(rd_pending));
    ex(32'h73); chk("data_r7_73", rd_data[63:32]);
    ex(1);      chk("iss_r7_ready_drained", DATA_W'(iss_ready));

    // issue to r0 accepted with no counter effect
    @(negedge clk); drive_iss(1'b1, 0); set_rd(0, 0); #1;
    ex(1); chk("iss_r0_ready", DATA_W'(iss_ready));
    @(negedge clk); drive_iss(1'b0, 0); #1;
    ex(0); chk("pend_r0", DATA_W'(rd_pending));

    // r9: simultaneous issue+wb, then underflow
    @(negedge clk); drive_iss(1'b1, 9);
    @(negedge clk); drive_wb(1'b1, 9, 32'h900);
    @(negedge clk); drive_iss(1'b0, 0); drive_wb(1'b0, 0, '0); set_rd(9, 9); #1;
    ex(2'b11);   chk("pend_r9_cnt1", DATA_W'(rd_pending));
    ex(32'h900); chk("data_r9_900", rd_data[31:0]);
    @(negedge clk); drive_wb(1'b1, 9, 32'h901);
    @(negedge clk); drive_wb(1'b0, 0, '0); #1;
    ex(0); chk("pend_r9_cnt0", DATA_W'(rd_pending));
    @(negedge clk); drive_wb(1'b1, 9, 32'h902);
    @(negedge clk); drive_wb(1'b0, 0, '0); #1;
    ex(0);       chk("pend_r9_extra_wb", DATA_W'(rd_pending));
    ex(32'h902); chk("data_r9_extra_wb", rd_data[63:32]);

    // same-cycle read of r3 during writeback
    @(negedge clk); drive_wb(1'b1, 3, 32'h11111111);
    @(negedge clk); drive_wb(1'b1, 3, 32'hA5A5A5A5); set_rd(0, 3); #1;
    ex(BYPASS ? 32'hA5A5A5A5 : 32'h11111111); chk("bypass_r3_same_cycle", rd_data[63:32]);
    ex(0); chk("bypass_r3_pend", DATA_W'(rd_pending[1]));
    @(negedge clk); drive_wb(1'b0, 0, '0); #1;
    ex(32'hA5A5A5A5); chk("r3_next_cycle", rd_data[63:32]);

    // mid-operation reset with an issue and a write presented
    @(negedge clk); drive_iss(1'b1, 2);
    @(negedge clk); drive_iss(1'b1, 2);
    @(negedge clk); drive_iss(1'b1, 4); drive_wb(1'b1, 2, 32'h22);
    @(negedge clk); drive_iss(1'b1, 4); drive_wb(1'b1, 4, 32'h44);
    @(negedge clk); drive_iss(1'b0, 0); drive_wb(1'b0, 0, '0); set_rd(2, 4); #1;
    ex(2'b11);  chk("pend_r2_r4", DATA_W'(rd_pending));
    ex(32'h22); chk("data_r2", rd_data[31:0]);
    ex(32'h44); chk("data_r4", rd_data[63:32]);
    @(negedge clk); rst = 1'b1; drive_iss(1'b1, 2); drive_wb(1'b1, 6, 32'h66); #1;
    ex(0); chk("iss_ready_mid_rst", DATA_W'(iss_ready));
    @(negedge clk); rst = 1'b0; drive_iss(1'b0, 0); drive_wb(1'b0, 0, '0); #1;
    ex(0); chk("post_rst_pend_r2_r4", DATA_W'(rd_pending));
    ex(0); chk("post_rst_data_r2", rd_data[31:0]);
    ex(0); chk("post_rst_data_r4", rd_data[63:32]);
    @(negedge clk); set_rd(6, 2); #1;
    ex(0); chk("post_rst_data_r6", rd_data[31:0]);
    ex(0); chk("post_rst_pend_r6_r2", DATA_W'(rd_pending));

    // final report
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised MIPS register file for the pipelined datapath.
- Successor to the fixed 32x32, 2-read-port file.
- Configurable width, depth and read-port count.
- Adds a per-register outstanding-write scoreboard, so decode can detect RAW hazards and stall.
- Sits between decode (read/issue) and writeback (write/retire).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- NUM_RD, 2, number of independent read ports.
- PEND_W, 2, width of each per-register outstanding-write counter (max 2^PEND_W-1 in flight).
- ADDR_W, $clog2(NUM_REGS), derived; not to be overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_pending  out  NUM_RD  1 when the register addressed by port k has an outstanding write.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- iss_valid  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  ADDR_W  destination of the issued instruction.
- iss_ready  out  1  issue accepted this cycle when iss_valid & iss_ready.

Behaviour:
- Storage:
  - NUM_REGS x DATA_W flops.
  - On rst: all registers 0, all pending counters 0.
  - rst has priority over wb_en and iss_valid in the same cycle.
  - A transaction presented during rst is dropped.
- Write:
  - At a clk edge with wb_en=1 and rst=0, reg[wb_addr] <= wb_data.
  - Ignored when wb_addr==0 or wb_addr>=NUM_REGS.
- Read:
  - Combinational: rd_data[k] = reg[rd_addr[k]].
  - Address 0 or an out-of-range address returns 0.
  - Without bypass, a write is visible the cycle after its edge.
- Scoreboard: one PEND_W-bit counter cnt[r] per register r>=1; cnt[0] is constant 0.
  - Accepted issue to r (r!=0, in range): cnt[r] +1.
  - wb_en to r: cnt[r] -1, saturating at 0; the data is still written and no error is raised.
  - Issue and wb_en to the same r in the same cycle: cnt[r] unchanged.
  - Issue to register 0 or an out-of-range address is accepted with no counter effect.
- rd_pending[k] = (cnt[rd_addr[k]] != 0). This is combinational from the current counters; it does not reflect a wb in the same cycle unless bypass is enabled.
- iss_ready:
  - 0 while rst=1.
  - Otherwise 0 only when cnt[iss_addr] == 2^PEND_W-1 and there is no wb_en to iss_addr in the same cycle.
  - Combinational; iss_valid is not required to depend on iss_ready.
- Reset mid-operation: all in-flight counts are lost. The pipeline is flushed by the same rst.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if wb_en=1, wb_addr!=0 and rd_addr[k]==wb_addr, then rd_data[k]=wb_data in the same cycle.
  - rd_pending[k] is computed as if that wb had already retired, i.e. (cnt-1)!=0.
- Undefined:
  - Reads return stored state only.
  - rd_pending uses the pre-edge counter.

Decomposition:
- Package regfile_sb_pkg holds:
  - default constants: DATA_W=32, NUM_REGS=32, NUM_RD=2, PEND_W=2;
  - the MIPS register index constants (ZERO=0, RA=31);
  - a pend_cnt_t typedef.
- Sub-module regfile_sb_ctr:
  - one saturating up/down counter, with inc, dec, rst inputs and cnt and full outputs;
  - instantiated by generate for registers 1..NUM_REGS-1.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0 and rd_pending=0 for every address; iss_ready=0 during rst, 1 after.
- wb_en to r5 with 0xDEADBEEF, read r5 next cycle -> 0xDEADBEEF. wb_en to r0 with 0x12345678 -> r0 still reads 0.
- Issue r7 three times (PEND_W=2) -> cnt=3, rd_pending=1, fourth issue to r7 sees iss_ready=0. The same cycle with wb_en to r7 -> iss_ready=1 and cnt stays 3.
- Issue r9 with wb_en to r9 in the same cycle at cnt=1 -> cnt stays 1. A following wb -> cnt 0, rd_pending=0. An extra wb -> cnt stays 0 and the data is written.
- With REGFILE_SB_BYPASS_EN, wb_en to r3 with 0xA5A5A5A5 while port 1 reads r3 -> rd_data[1]=0xA5A5A5A5 in the same cycle. Without the macro -> old value, new value next cycle.
- Counters nonzero on r2 and r4 and stored data, assert rst 1 cycle together with iss_valid -> after rst all counters and registers 0, and the issue is dropped.
